// File: rtl/bcd2binary.sv
// Packed-BCD to unsigned binary converter (reverse double-dabble).
// Each step shifts the BCD register right by one bit into the MSB of the binary
// accumulator. Any digit that is then >= 8 has 3 subtracted from it.
// After DOUT_W steps the accumulator holds the binary value.
module bcd2binary #(
    parameter int unsigned DIGITS = 6,
    parameter int unsigned DIN_W  = 4 * DIGITS,
    parameter int unsigned DOUT_W = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DIN_W-1:0]  bcd_din,
    output logic              busy,
    output logic [DOUT_W-1:0] binary_dout,
    output logic              binary_dout_vld,
    output logic              bcd_err
);

    localparam int unsigned     CntW    = $clog2(DOUT_W);
    localparam logic [CntW-1:0] LastCnt = CntW'(DOUT_W - 1);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StDone  = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [DIN_W-1:0]    bcd_q, bcd_d;
    logic [DOUT_W-1:0]   acc_q, acc_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic                err_q, err_d;
    logic [DOUT_W-1:0]   dout_q, dout_d;
    logic                vld_q, vld_d;
    logic                bcd_err_q, bcd_err_d;

    logic                din_err;
    logic [DIN_W-1:0]    bcd_shr;
    logic [DIN_W-1:0]    bcd_fix;

    // Flag any input digit outside 0..9.
    always_comb begin
        din_err = 1'b0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (bcd_din[4*i +: 4] > 4'd9) begin
                din_err = 1'b1;
            end
        end
    end

    // Shift right, then pull every digit >= 8 back down by 3. A digit >= 8
    // has bit 3 set, and subtracting 3 from it cannot underflow.
    always_comb begin
        bcd_shr = {1'b0, bcd_q[DIN_W-1:1]};
        bcd_fix = bcd_shr;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (bcd_shr[4*i+3]) begin
                bcd_fix[4*i +: 4] = bcd_shr[4*i +: 4] - 4'd3;
            end
        end
    end

    // Next-state logic for the FSM and its datapath.
    always_comb begin
        state_d   = state_q;
        bcd_d     = bcd_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        dout_d    = dout_q;
        vld_d     = 1'b0;
        bcd_err_d = bcd_err_q;
        case (state_q)
            StIdle: begin
                if (en) begin
                    bcd_d   = bcd_din;
                    acc_d   = '0;
                    cnt_d   = '0;
                    err_d   = din_err;
                    state_d = StShift;
                end
            end
            StShift: begin
                acc_d = {bcd_q[0], acc_q[DOUT_W-1:1]};
                bcd_d = bcd_fix;
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == LastCnt) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                // An invalid digit makes the accumulated value meaningless.
                dout_d    = err_q ? '0 : acc_q;
                bcd_err_d = err_q;
                vld_d     = 1'b1;
                state_d   = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers. Reset aborts any conversion in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            bcd_q     <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            dout_q    <= '0;
            vld_q     <= 1'b0;
            bcd_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            bcd_q     <= bcd_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            dout_q    <= dout_d;
            vld_q     <= vld_d;
            bcd_err_q <= bcd_err_d;
        end
    end

    assign busy            = (state_q != StIdle);
    assign binary_dout     = dout_q;
    assign binary_dout_vld = vld_q;
    assign bcd_err         = bcd_err_q;

endmodule

// File: tb/tb_bcd2binary.sv
// Self-checking bench for bcd2binary against a decimal reference model.
module tb_bcd2binary;

    localparam int unsigned DIGITS = 6;
    localparam int unsigned DIN_W  = 24;
    localparam int unsigned DOUT_W = 20;
    localparam int          Lat    = 21;
    localparam int          Period = 22;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              en = 1'b0;
    logic [DIN_W-1:0]  bcd_din = '0;
    logic              busy;
    logic [DOUT_W-1:0] binary_dout;
    logic              binary_dout_vld;
    logic              bcd_err;

    int n_checks = 0;
    int n_errs   = 0;

    bcd2binary #(
        .DIGITS (DIGITS),
        .DIN_W  (DIN_W),
        .DOUT_W (DOUT_W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .en              (en),
        .bcd_din         (bcd_din),
        .busy            (busy),
        .binary_dout     (binary_dout),
        .binary_dout_vld (binary_dout_vld),
        .bcd_err         (bcd_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    // Decimal reference: value = sum(digit_i * 10^i), zero if any digit > 9.
    function automatic void model(input logic [DIN_W-1:0] b, output int unsigned v,
                                  output bit e);
        logic [3:0] d;
        v = 0;
        e = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            d = b[4*i +: 4];
            if (d > 4'd9) e = 1'b1;
            v = v * 10 + int'(d);
        end
        if (e) v = 0;
    endfunction

    // Launch one conversion from IDLE and measure latency and busy time.
    task automatic run_conv(input logic [DIN_W-1:0] b, output logic [DOUT_W-1:0] dout,
                            output logic err, output int lat, output int busy_cnt);
        @(negedge clk);
        en      = 1'b1;
        bcd_din = b;
        @(negedge clk);
        en       = 1'b0;
        bcd_din  = DIN_W'($urandom);
        lat      = 0;
        busy_cnt = 0;
        while (!binary_dout_vld && lat < 40) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            lat++;
        end
        dout = binary_dout;
        err  = bcd_err;
    endtask

    task automatic conv_check(input logic [DIN_W-1:0] b);
        logic [DOUT_W-1:0] dout;
        logic              err;
        int                lat, busy_cnt;
        int unsigned       exp_v;
        bit                exp_e;
        model(b, exp_v, exp_e);
        run_conv(b, dout, err, lat, busy_cnt);
        check_eq($sformatf("lat[%06h]", b), lat, Lat);
        check_eq($sformatf("busy[%06h]", b), busy_cnt, Lat);
        check_eq($sformatf("dout[%06h]", b), 32'(dout), exp_v);
        check_eq($sformatf("err[%06h]", b), 32'(err), 32'(exp_e));
        @(negedge clk);
        check_eq($sformatf("vld_width[%06h]", b), 32'(binary_dout_vld), 0);
    endtask

    initial begin
        int                cnt;
        int                vcnt;
        logic [DOUT_W-1:0] seen;
        logic [DIN_W-1:0]  rb;

        // Reset state
        #2;
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_dout", 32'(binary_dout), 0);
        check_eq("rst_vld", 32'(binary_dout_vld), 0);
        check_eq("rst_err", 32'(bcd_err), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Directed values, including an invalid digit and recovery from it
        conv_check(24'h000000);
        conv_check(24'h999999);
        conv_check(24'h000151);
        conv_check(24'h123456);
        conv_check(24'h00A123);
        conv_check(24'h000010);

        // Reset in the middle of a conversion
        @(negedge clk);
        en      = 1'b1;
        bcd_din = 24'h999999;
        @(negedge clk);
        en = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("midrst_busy", 32'(busy), 0);
        check_eq("midrst_dout", 32'(binary_dout), 0);
        check_eq("midrst_vld", 32'(binary_dout_vld), 0);
        check_eq("midrst_err", 32'(bcd_err), 0);
        repeat (2) @(negedge clk);
        rst  = 1'b0;
        vcnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (binary_dout_vld) vcnt++;
        end
        check_eq("midrst_no_vld", vcnt, 0);
        conv_check(24'h000042);

        // en held high with alternating inputs: back-to-back conversions
        @(negedge clk);
        en      = 1'b1;
        bcd_din = 24'h000001;
        @(negedge clk);
        bcd_din = 24'h500000;
        cnt     = 0;
        for (int k = 0; k < 4; k++) begin
            while (!binary_dout_vld && cnt < 40) begin
                @(negedge clk);
                cnt++;
            end
            check_eq($sformatf("hold_interval%0d", k), cnt, (k == 0) ? Lat : Period);
            check_eq($sformatf("hold_dout%0d", k), 32'(binary_dout), (k % 2) ? 500000 : 1);
            @(negedge clk);
            cnt = 1;
            check_eq($sformatf("hold_vld_width%0d", k), 32'(binary_dout_vld), 0);
            // Value for the conversion two results ahead
            bcd_din = (k % 2) ? 24'h500000 : 24'h000001;
        end
        en  = 1'b0;
        cnt = 0;
        while (!binary_dout_vld && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        @(negedge clk);

        // en pulses while busy must not start or queue anything
        @(negedge clk);
        en      = 1'b1;
        bcd_din = 24'h000777;
        vcnt    = 0;
        seen    = '0;
        for (int i = 0; i <= 45; i++) begin
            @(negedge clk);
            if (binary_dout_vld) begin
                vcnt++;
                seen = binary_dout;
            end
            en      = (i == 4 || i == 9 || i == 14);
            bcd_din = en ? 24'h000123 : 24'h000777;
        end
        en = 1'b0;
        check_eq("pulse_vld_count", vcnt, 1);
        check_eq("pulse_dout", 32'(seen), 777);

        // Randomised sweep of valid BCD values
        for (int n = 0; n < 2000; n++) begin
            for (int d = 0; d < int'(DIGITS); d++) begin
                rb[4*d +: 4] = 4'($urandom_range(0, 9));
            end
            conv_check(rb);
        end

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
